extram_unaligned_reader: RTL
============================

Name: extram_unaligned_reader

Overview:
- Read-side companion to the ExtendRAM write-path left rotator.
- Accepts a byte-addressed load of 1/2/4 units at any alignment and issues one or two aligned word reads to ExtendRAM.
- Funnels the two words right by the byte offset, then masks and sign/zero-extends the result.
- Sits between the LSU load port and the ExtendRAM read port.

Parameters:
UNITW, 8, bits per RAM unit (byte lane)
GROUP, 4, units per RAM word; power of two, >= 2
ADDRW, 32, request byte-address width
(derived: OFFW = clog2(GROUP); SZW = clog2(OFFW+1))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  load request valid
req_ready  output  1  block can accept a request
req_addr  input  ADDRW  byte address
req_size  input  SZW  log2 of unit count; values > OFFW treated as OFFW
req_signed  input  1  1 = sign-extend, 0 = zero-extend
ram_en  output  1  RAM read enable
ram_addr  output  ADDRW-OFFW  RAM word address
ram_rdata  input  UNITW*GROUP  RAM read data, valid the cycle after ram_en
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  UNITW*GROUP  assembled, extended load data
rsp_err  output  1  misalignment trap flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while in reset; all other outputs and internal registers = 0. Reset mid-operation discards the in-flight request; no RAM read or response is issued for it.
- States: IDLE, RD_LO, CAP_LO, CAP_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch word=addr[ADDRW-1:OFFW], off=addr[OFFW-1:0], clamped size, signed; go to RD_LO.
  - cross = (off + 2^size > GROUP).
- RD_LO: ram_en=1, ram_addr=word. Next state CAP_LO.
- CAP_LO:
  - lo <= ram_rdata.
  - If cross: ram_en=1, ram_addr=word+1 (modulo 2^(ADDRW-OFFW), so the top word wraps to 0); next CAP_HI.
  - Else: hi treated as 0; assemble; next RESP.
- CAP_HI: hi <= ram_rdata; assemble; next RESP.
- Assemble, registered into rsp_data on entry to RESP:
  - t = {hi,lo} >> (off*UNITW); keep the low GROUP units.
  - Keep the low 2^size units.
  - If signed, replicate the MSB of the kept field into the upper bits; otherwise zero them.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1.
  - On handshake: rsp_valid goes to 0 next cycle; next state IDLE.
- ram_en=0 in all states/conditions not listed above; req_ready=0 outside IDLE, so there is no request overlap. A request presented in the cycle of the rsp handshake is not accepted; it is accepted in the following IDLE cycle.
- Latency from accept edge to rsp_valid high: 3 cycles non-crossing, 4 cycles crossing.
- Full-word aligned (off=0, size=OFFW) is non-crossing.

Optional Feature:
- Macro EXTRAM_ALIGN_TRAP_EN.
- Defined:
  - A crossing request skips the second read: CAP_LO goes directly to RESP.
  - Response has rsp_err=1 and rsp_data=0; latency 3 cycles.
  - Non-crossing requests behave as normal, with rsp_err=0.
- Undefined: crossing requests are split into two reads; rsp_err is constant 0; the trap logic is not synthesized.

Test Plan:
- Setup for all scenarios: RAM word0=0x44332211, word1=0x88776655, word 2^(ADDRW-2)-1 = 0xDDCCBBAA (GROUP=4).
- Non-crossing: addr=1, size=1, unsigned -> exactly one ram_en pulse (addr 0); rsp_data=0x00003322; rsp_valid 3 cycles after accept.
- Crossing: addr=3, size=2 -> ram_en pulses at word 0, then word 1; rsp_data=0x77665544; latency 4; rsp_err=0 (macro off).
- Sign extension: addr=7, size=0, signed -> 0xFFFFFF88; same request unsigned -> 0x00000088.
- Wrap-around: addr=0xFFFFFFFE, size=2 -> second ram_addr=0; rsp_data=0x2211DDCC.
- Backpressure and reset:
  - Crossing response with rsp_ready=0 for 5 cycles -> rsp_data stable; req_ready=0; no ram_en.
  - Separately, rst_n pulsed low during CAP_LO -> all outputs 0 immediately; a following addr=0, size=2 request returns 0x44332211.
- With EXTRAM_ALIGN_TRAP_EN: addr=3, size=2 -> single ram_en; rsp_err=1; rsp_data=0; latency 3. Then addr=4, size=2 -> 0x88776655 with rsp_err=0.

Source files
------------

// File: rtl/extram_unaligned_reader.sv
// rtl/extram_unaligned_reader.sv - unaligned 1/2/4-unit load reader for ExtendRAM (one or two word reads, funnel + extend)
// Optional misaligned-load trap: EXTRAM_ALIGN_TRAP_EN
module extram_unaligned_reader #(
  parameter int UNITW = 8,
  parameter int GROUP = 4,
  parameter int ADDRW = 32,
  localparam int OFFW = $clog2(GROUP),
  localparam int SZW  = $clog2(OFFW + 1),
  localparam int DW   = UNITW * GROUP,
  localparam int WAW  = ADDRW - OFFW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [SZW-1:0]   req_size,
  input  logic             req_signed,
  output logic             ram_en,
  output logic [WAW-1:0]   ram_addr,
  input  logic [DW-1:0]    ram_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_CAP_LO = 3'd2,
    S_CAP_HI = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAW-1:0]    r_word;
  logic [OFFW-1:0]   r_off;
  logic [SZW-1:0]    r_size;
  logic              r_signed;
  logic [DW-1:0]     r_lo;
  logic [DW-1:0]     r_data;
  logic [SZW-1:0]    w_size_clamp;
  logic [OFFW:0]     w_span;
  logic              w_cross;
  logic [DW-1:0]     w_hi;
  logic [DW-1:0]     w_lo;
  logic [2*DW-1:0]   w_cat;
  logic [DW-1:0]     w_t;
  logic              w_sign;
  logic [DW-1:0]     w_asm;

  assign w_size_clamp = (req_size > SZW'(OFFW)) ? SZW'(OFFW) : req_size;
  assign w_span       = {1'b0, r_off} + ((OFFW+1)'(1) << r_size);
  assign w_cross      = (w_span > (OFFW+1)'(GROUP));

  // In CAP_LO the low word is still on the RAM bus; in CAP_HI it has been captured into r_lo.
  assign w_hi  = (r_state == S_CAP_HI) ? ram_rdata : '0;
  assign w_lo  = (r_state == S_CAP_HI) ? r_lo : ram_rdata;
  assign w_cat = {w_hi, w_lo};
  assign w_t   = DW'(w_cat >> (32'(r_off) * UNITW));

  always_comb begin
    w_sign = 1'b0;
    w_asm  = '0;
    for (int u = 0; u < GROUP; u++) begin
      if (u == (1 << r_size) - 1)
        w_sign = w_t[u*UNITW + UNITW - 1];
    end
    for (int u = 0; u < GROUP; u++) begin
      if (u < (1 << r_size))
        w_asm[u*UNITW +: UNITW] = w_t[u*UNITW +: UNITW];
      else
        w_asm[u*UNITW +: UNITW] = {UNITW{r_signed & w_sign}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_RD_LO;
      S_RD_LO:  w_next = S_CAP_LO;
`ifdef EXTRAM_ALIGN_TRAP_EN
      S_CAP_LO: w_next = S_RESP;
`else
      S_CAP_LO: w_next = w_cross ? S_CAP_HI : S_RESP;
`endif
      S_CAP_HI: w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    ram_en    = 1'b0;
    ram_addr  = '0;
    case (r_state)
      S_RD_LO: begin
        ram_en   = 1'b1;
        ram_addr = r_word;
      end
      S_CAP_LO: begin
`ifndef EXTRAM_ALIGN_TRAP_EN
        if (w_cross) begin
          ram_en   = 1'b1;
          ram_addr = r_word + WAW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word   <= '0;
      r_off    <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_lo     <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word   <= req_addr[ADDRW-1:OFFW];
            r_off    <= req_addr[OFFW-1:0];
            r_size   <= w_size_clamp;
            r_signed <= req_signed;
          end
        end
        S_CAP_LO: begin
          r_lo <= ram_rdata;
`ifdef EXTRAM_ALIGN_TRAP_EN
          r_data <= w_cross ? '0 : w_asm;
`else
          if (!w_cross) r_data <= w_asm;
`endif
        end
        S_CAP_HI: r_data <= w_asm;
        default: ;
      endcase
    end
  end

`ifdef EXTRAM_ALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_err <= 1'b0;
    else if (r_state == S_CAP_LO) r_err <= w_cross;
  end
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_data = r_data;

endmodule
